bus_wait_ctl: RTL and testbench

Synchronous wait-state controller for the CPU memory/IO bus. It drives n_rdy in place of the hard-tied "always ready" level, stretching each access by a per-region wait count. Regions are ROM, low RAM, high RAM and the IO page. Wait counts live in an 8-bit config register mapped at the spare IO decoder slot (0xFF06/0xFF07), so software can tune bus timing at runtime.

---
 rtl/bus_pkg.sv | 38 +++
 rtl/bus_wait_ctl_if.sv | 22 ++
 rtl/bus_region_dec.sv | 32 +++
 rtl/bus_wait_ctl.sv | 123 ++++++++++++
 tb/tb_bus_wait_ctl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus wait-state controller and its region decoder.
// Region codes double as the index of each 2-bit field inside the wait config byte.
package bus_pkg;

   typedef enum logic [1:0] {
      RGN_ROM  = 2'd0,
      RGN_RAML = 2'd1,
      RGN_RAMH = 2'd2,
      RGN_IO   = 2'd3
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int WCFG_ROM_LSB  = 0;
   localparam int WCFG_RAML_LSB = 2;
   localparam int WCFG_RAMH_LSB = 4;
   localparam int WCFG_IO_LSB   = 6;

   localparam logic [7:0] IO_PAGE_DEFAULT    = 8'hFF;
   localparam logic [7:0] WCFG_RESET_DEFAULT = 8'h41;
   localparam logic [1:0] CFG_SLOT           = 2'b11;

   function automatic logic [1:0] wait_field(input logic [7:0] wcfg, input region_e rgn);
      logic [1:0] n;
      case (rgn)
         RGN_ROM:  n = wcfg[WCFG_ROM_LSB  +: 2];
         RGN_RAML: n = wcfg[WCFG_RAML_LSB +: 2];
         RGN_RAMH: n = wcfg[WCFG_RAMH_LSB +: 2];
         default:  n = wcfg[WCFG_IO_LSB   +: 2];
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bus_wait_ctl_if.sv
// CPU-side bus bundle seen by the wait-state controller.
// The CPU/bench drives the master side; the controller is the slave.
interface bus_wait_ctl_if;
   logic [15:0] a;
   logic [7:0]  d;
   logic        n_oe;
   logic        n_we;
   logic [7:0]  cr;
   logic        n_rdy;
   logic [7:0]  wcfg;
   logic        busy;

   modport master (
      output a, d, n_oe, n_we, cr,
      input  n_rdy, wcfg, busy
   );

   modport slave (
      input  a, d, n_oe, n_we, cr,
      output n_rdy, wcfg, busy
   );
endinterface

// File: rtl/bus_region_dec.sv
// Combinational address/control decode into a bus region and its configured wait count.
// Shared with the board chip-select logic so both always agree on region boundaries.
module bus_region_dec
   import bus_pkg::*;
#(
   parameter logic [7:0] IO_PAGE = IO_PAGE_DEFAULT
) (
   input  logic [15:0] a,
   input  logic [7:0]  cr,
   input  logic [7:0]  wcfg,
   output region_e     region,
   output logic [1:0]  wait_n
);

   // First match wins: the IO page sits inside high RAM and must shadow it.
   always_comb begin
      region = RGN_ROM;
      if (a[15:8] == IO_PAGE) begin
         region = RGN_IO;
      end else if (a[15]) begin
         region = RGN_RAMH;
      end else if (cr[0]) begin
         region = RGN_RAML;
      end
   end

   assign wait_n = wait_field(wcfg, region);

   logic unused_bits;
   assign unused_bits = ^{a[7:0], cr[7:1]};

endmodule

// File: rtl/bus_wait_ctl.sv
// Wait-state controller: stretches each CPU access by the region's wait count and
// holds the runtime-writable wait configuration register at the IO config slot.
module bus_wait_ctl
   import bus_pkg::*;
#(
   parameter logic [7:0] WCFG_RESET = WCFG_RESET_DEFAULT,
   parameter logic [7:0] IO_PAGE    = IO_PAGE_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   bus_wait_ctl_if.slave  bus
);

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       n_rdy_q, n_rdy_d;
   logic       strb_q, strb_d;
   logic       n_we_q, n_we_d;
   logic [7:0] wcfg_q, wcfg_d;
   logic [7:0] wdata_q, wdata_d;
   logic       wflag_q, wflag_d;

   logic       strb;
   logic       start;
   logic       cfg_hit;
   logic       we_rise;
   logic [1:0] wait_n;
   region_e    region_unused;

   bus_region_dec #(
      .IO_PAGE (IO_PAGE)
   ) u_region_dec (
      .a      (bus.a),
      .cr     (bus.cr),
      .wcfg   (wcfg_q),
      .region (region_unused),
      .wait_n (wait_n)
   );

   assign strb    = ~bus.n_oe | ~bus.n_we;
   assign start   = strb & ~strb_q;
   assign cfg_hit = (bus.a[15:8] == IO_PAGE) && (bus.a[2:1] == CFG_SLOT) && !bus.n_we && bus.n_oe;
   assign we_rise = ~n_we_q & bus.n_we;

   // Access sequencing; wait_n comes from wcfg_q, so a same-edge commit never affects this start.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (wait_n == 2'd0) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = wait_n;
               end
            end
         end
         ST_WAIT: begin
            if (!strb) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 2'd1) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_HOLD: begin
            if (!strb) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      n_rdy_d = (state_d == ST_WAIT);
   end

   // Config data is staged during the strobe and only becomes live when n_we rises.
   always_comb begin
      strb_d  = strb;
      n_we_d  = bus.n_we;
      wcfg_d  = wcfg_q;
      wdata_d = wdata_q;
      wflag_d = wflag_q;
      if (we_rise) begin
         wflag_d = 1'b0;
         if (wflag_q) begin
            wcfg_d = wdata_q;
         end
      end else if (cfg_hit) begin
         wflag_d = 1'b1;
         wdata_d = bus.d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         n_rdy_q <= 1'b0;
         strb_q  <= 1'b0;
         n_we_q  <= 1'b1;
         wcfg_q  <= WCFG_RESET;
         wdata_q <= 8'h00;
         wflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_rdy_q <= n_rdy_d;
         strb_q  <= strb_d;
         n_we_q  <= n_we_d;
         wcfg_q  <= wcfg_d;
         wdata_q <= wdata_d;
         wflag_q <= wflag_d;
      end
   end

   assign bus.n_rdy = n_rdy_q;
   assign bus.busy  = n_rdy_q;
   assign bus.wcfg  = wcfg_q;

endmodule

// File: tb/tb_bus_wait_ctl.sv
// Bench for bus_wait_ctl: directed scenarios with literal expectations, then random
// accesses, all checked every cycle against a stall-budget model of the bus rules.
module tb_bus_wait_ctl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_wait_ctl_if bus_if ();

   bus_wait_ctl #(
      .WCFG_RESET (8'h41),
      .IO_PAGE    (8'hFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: stall clocks still owed to the current access, plus the config register image.
   logic [7:0] m_wcfg;
   logic [7:0] m_pdata;
   bit         m_pend;
   bit         m_strb_prev;
   bit         m_we_prev;
   bit         m_strb_now;
   int         m_rem;
   bit         m_valid = 1'b0;

   function automatic int wait_for(input logic [15:0] ad, input logic [7:0] c, input logic [7:0] w);
      int         idx;
      logic [7:0] sh;
      if (ad[15:8] == 8'hFF)  idx = 3;
      else if (ad[15])        idx = 2;
      else if (c[0])          idx = 1;
      else                    idx = 0;
      sh = w >> (2 * idx);
      return int'(sh[1:0]);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_wcfg      = 8'h41;
         m_pend      = 1'b0;
         m_strb_prev = 1'b0;
         m_we_prev   = 1'b1;
         m_rem       = 0;
         m_valid     = 1'b1;
      end else if (m_valid) begin
         m_strb_now = !bus_if.n_oe || !bus_if.n_we;
         if (m_strb_now && !m_strb_prev)
            m_rem = wait_for(bus_if.a, bus_if.cr, m_wcfg);
         else if (!m_strb_now)
            m_rem = 0;
         else if (m_rem > 0)
            m_rem = m_rem - 1;
         if (!m_we_prev && bus_if.n_we) begin
            if (m_pend) m_wcfg = m_pdata;
            m_pend = 1'b0;
         end
         if (bus_if.a[15:8] == 8'hFF && bus_if.a[2:1] == 2'b11 && !bus_if.n_we && bus_if.n_oe) begin
            m_pend  = 1'b1;
            m_pdata = bus_if.d;
         end
         m_strb_prev = m_strb_now;
         m_we_prev   = bus_if.n_we;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid && !rst) begin
         check("cyc_n_rdy", 32'(bus_if.n_rdy), 32'(m_rem > 0));
         check("cyc_busy",  32'(bus_if.busy),  32'(m_rem > 0));
         check("cyc_wcfg",  32'(bus_if.wcfg),  32'(m_wcfg));
      end
   end

   task automatic access(input logic [15:0] addr, input logic [7:0] data, input bit oe_n,
                         input bit we_n, input int hold, output int stalls);
      @(negedge clk);
      bus_if.a    = addr;
      bus_if.d    = data;
      bus_if.n_oe = oe_n;
      bus_if.n_we = we_n;
      stalls = 0;
      repeat (hold) begin
         @(negedge clk);
         if (bus_if.n_rdy) stalls++;
      end
      bus_if.n_oe = 1'b1;
      bus_if.n_we = 1'b1;
   endtask

   int st;

   initial begin
      rst         = 1'b1;
      bus_if.a    = 16'h0000;
      bus_if.d    = 8'h00;
      bus_if.n_oe = 1'b1;
      bus_if.n_we = 1'b1;
      bus_if.cr   = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_wcfg",  32'(bus_if.wcfg),  32'h41);
      check("reset_n_rdy", 32'(bus_if.n_rdy), 32'h0);
      check("reset_busy",  32'(bus_if.busy),  32'h0);

      access(16'h0100, 8'h00, 1'b0, 1'b1, 3, st);
      check("rom_read_stalls", 32'(st), 32'd1);

      bus_if.cr = 8'h01;
      access(16'h0200, 8'h00, 1'b0, 1'b1, 2, st);
      check("raml_read_stalls", 32'(st), 32'd0);
      access(16'h8000, 8'h00, 1'b0, 1'b1, 2, st);
      check("ramh_read_stalls", 32'(st), 32'd0);

      access(16'hFF06, 8'hFF, 1'b1, 1'b0, 2, st);
      check("cfg_write_stalls", 32'(st), 32'd1);
      @(negedge clk);
      check("cfg_commit_ff", 32'(bus_if.wcfg), 32'hFF);
      access(16'hFF00, 8'h00, 1'b0, 1'b1, 4, st);
      check("io_read_3wait", 32'(st), 32'd3);

      access(16'hFF07, 8'hC0, 1'b1, 1'b0, 4, st);
      check("cfg_write_c0_stalls", 32'(st), 32'd3);
      @(negedge clk);
      check("cfg_commit_c0", 32'(bus_if.wcfg), 32'hC0);

      access(16'hFF00, 8'h00, 1'b0, 1'b1, 1, st);
      check("abort_stalls", 32'(st), 32'd1);
      @(negedge clk);
      check("abort_release", 32'(bus_if.n_rdy), 32'h0);
      access(16'hFF00, 8'h00, 1'b0, 1'b1, 4, st);
      check("after_abort_stalls", 32'(st), 32'd3);

      access(16'hFF06, 8'h02, 1'b1, 1'b0, 4, st);
      bus_if.cr = 8'h00;
      access(16'h0100, 8'h00, 1'b0, 1'b1, 3, st);
      check("b2b_rom_first", 32'(st), 32'd2);
      access(16'h0140, 8'h00, 1'b0, 1'b1, 3, st);
      check("b2b_rom_second", 32'(st), 32'd2);

      // Address moves while n_oe stays low: only one stall window.
      @(negedge clk);
      bus_if.a = 16'h0100;
      bus_if.n_oe = 1'b0;
      st = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus_if.n_rdy) st++;
         if (i == 1) bus_if.a = 16'h0300;
      end
      bus_if.n_oe = 1'b1;
      check("addr_change_stalls", 32'(st), 32'd2);

      access(16'hFF07, 8'hC0, 1'b1, 1'b0, 2, st);
      check("cfg_write_io0", 32'(st), 32'd0);
      @(negedge clk);
      bus_if.a    = 16'hFF00;
      bus_if.n_oe = 1'b0;
      @(negedge clk);
      check("midwait_stalling", 32'(bus_if.n_rdy), 32'h1);
      rst         = 1'b1;
      bus_if.n_oe = 1'b1;
      @(negedge clk);
      check("midwait_reset_n_rdy", 32'(bus_if.n_rdy), 32'h0);
      check("midwait_reset_wcfg",  32'(bus_if.wcfg),  32'h41);
      rst = 1'b0;

      access(16'hFF06, 8'h00, 1'b0, 1'b0, 3, st);
      check("both_strobe_stalls", 32'(st), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("both_strobe_no_write", 32'(bus_if.wcfg), 32'h41);

      for (int it = 0; it < 400; it++) begin
         logic [15:0] ad;
         int          cls;
         int          kind;
         bit          oe_n;
         bit          we_n;
         if ($urandom_range(0, 39) == 0) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         ad  = 16'($urandom);
         cls = int'($urandom_range(0, 3));
         case (cls)
            0: begin ad[15:8] = 8'hFF; ad[2:1] = 2'b11; end
            1: ad[15:8] = 8'hFF;
            2: ad[15] = 1'b1;
            default: ad[15] = 1'b0;
         endcase
         kind = int'($urandom_range(0, 3));
         oe_n = (kind == 1);
         we_n = (kind != 1) && (kind != 2);
         bus_if.cr = 8'($urandom);
         access(ad, 8'($urandom), oe_n, we_n, int'($urandom_range(1, 5)), st);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
